// File: rtl/alu_issue.sv
// Decode-and-issue stage: takes one RV32I instruction, reads its sources, strobes the
// ALU once, waits for the result to settle and emits a single result/redirect record.
module alu_issue #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] instr_pc_i,
  input  logic        flush_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic [31:0] a_in_o,
  output logic [31:0] b_in_o,
  output logic [4:0]  alu_control_o,
  output logic [31:0] pc_o,
  output logic        tick_idex_o,
  input  logic [31:0] alu_result_i,
  input  logic [2:0]  branch_taken_i,
  output logic        res_valid_o,
  output logic [31:0] res_data_o,
  output logic [4:0]  res_rd_o,
  output logic        res_we_o,
  output logic        res_redirect_o,
  output logic [31:0] res_target_o,
  output logic        illegal_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [15:0] LAST_WAIT = 16'(SETTLE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] instr_q, ipc_q;
  logic [31:0] a_q, b_q, pc_q, tgt_q;
  logic [4:0]  ctl_q, rd_q;
  logic        we_q, br_q, jmp_q;
  logic [15:0] cnt_q;
  logic [31:0] res_data_q, res_target_q;
  logic [4:0]  res_rd_q;
  logic        res_we_q, res_redirect_q, illegal_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_b, imm_j, imm_u, shamt;
  logic        dec_ill, dec_wr, dec_br, dec_jmp;
  logic [4:0]  dec_ctl;
  logic [31:0] dec_a, dec_b, dec_tgt;

  assign opcode = instr_q[6:0];
  assign f3     = instr_q[14:12];
  assign f7     = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign shamt  = {27'b0, instr_q[24:20]};

  // Decode of the latched instruction; SLT-family, memory and system ops are rejected.
  always_comb begin
    dec_ill = 1'b0;
    dec_wr  = 1'b0;
    dec_br  = 1'b0;
    dec_jmp = 1'b0;
    dec_ctl = 5'b00000;
    dec_a   = rs1_data_i;
    dec_b   = rs2_data_i;
    dec_tgt = 32'h0;
    case (opcode)
      7'b0110011: begin
        dec_wr = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec_ctl = 5'b00000;
          10'b0100000_000: dec_ctl = 5'b00001;
          10'b0000000_111: dec_ctl = 5'b00011;
          10'b0000000_110: dec_ctl = 5'b00100;
          10'b0000000_100: dec_ctl = 5'b00101;
          10'b0000000_001: dec_ctl = 5'b01000;
          10'b0000000_101: dec_ctl = 5'b01010;
          10'b0100000_101: dec_ctl = 5'b01011;
          default:         dec_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_wr = 1'b1;
        dec_b  = imm_i;
        case (f3)
          3'b000: dec_ctl = 5'b00000;
          3'b111: dec_ctl = 5'b00011;
          3'b110: dec_ctl = 5'b00100;
          3'b100: dec_ctl = 5'b00101;
          3'b001: begin
            dec_b   = shamt;
            dec_ctl = 5'b01000;
            dec_ill = (f7 != 7'b0000000);
          end
          3'b101: begin
            dec_b = shamt;
            if (f7 == 7'b0000000)      dec_ctl = 5'b01010;
            else if (f7 == 7'b0100000) dec_ctl = 5'b01011;
            else                       dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        dec_br  = 1'b1;
        dec_tgt = ipc_q + imm_b;
        case (f3)
          3'b000:  dec_ctl = 5'b00111;
          3'b001:  dec_ctl = 5'b01110;
          3'b100:  dec_ctl = 5'b00110;
          3'b101:  dec_ctl = 5'b01111;
          3'b110:  dec_ctl = 5'b01001;
          3'b111:  dec_ctl = 5'b10000;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0110111: begin
        dec_wr  = 1'b1;
        dec_a   = 32'h0;
        dec_b   = imm_u;
        dec_ctl = 5'b01100;
      end
      7'b0010111: begin
        dec_wr  = 1'b1;
        dec_a   = 32'h0;
        dec_b   = imm_u;
        dec_ctl = 5'b01101;
      end
      7'b1101111: begin
        dec_wr  = 1'b1;
        dec_jmp = 1'b1;
        dec_a   = 32'h0;
        dec_b   = 32'h0;
        dec_ctl = 5'b10010;
        dec_tgt = ipc_q + imm_j;
      end
      7'b1100111: begin
        dec_wr  = 1'b1;
        dec_jmp = 1'b1;
        dec_b   = imm_i;
        dec_ctl = 5'b10001;
        dec_tgt = (rs1_data_i + imm_i) & 32'hFFFF_FFFE;
        dec_ill = (f3 != 3'b000);
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Flush aborts only the speculative states; DONE has already committed its result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid_i) state_d = READ;
      READ:    state_d = flush_i ? IDLE : (dec_ill ? DONE : ISSUE);
      ISSUE:   state_d = flush_i ? IDLE : WAIT;
      WAIT:    if (flush_i) state_d = IDLE;
               else if (cnt_q == LAST_WAIT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      ipc_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      pc_q           <= '0;
      tgt_q          <= '0;
      ctl_q          <= '0;
      rd_q           <= '0;
      we_q           <= 1'b0;
      br_q           <= 1'b0;
      jmp_q          <= 1'b0;
      cnt_q          <= '0;
      res_data_q     <= '0;
      res_target_q   <= '0;
      res_rd_q       <= '0;
      res_we_q       <= 1'b0;
      res_redirect_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid_i) begin
        instr_q <= instr_i;
        ipc_q   <= instr_pc_i;
      end
      if (state_q == READ && !flush_i) begin
        a_q   <= dec_a;
        b_q   <= dec_b;
        ctl_q <= dec_ctl;
        pc_q  <= ipc_q;
        tgt_q <= dec_tgt;
        rd_q  <= instr_q[11:7];
        we_q  <= dec_wr && (instr_q[11:7] != 5'd0);
        br_q  <= dec_br;
        jmp_q <= dec_jmp;
        if (dec_ill) begin
          res_data_q     <= '0;
          res_target_q   <= '0;
          res_rd_q       <= instr_q[11:7];
          res_we_q       <= 1'b0;
          res_redirect_q <= 1'b0;
          illegal_q      <= 1'b1;
        end
      end
      if (state_q == ISSUE) cnt_q <= '0;
      if (state_q == WAIT && !flush_i) begin
        cnt_q <= cnt_q + 16'd1;
        if (cnt_q == LAST_WAIT) begin
          res_data_q     <= alu_result_i;
          res_target_q   <= tgt_q;
          res_rd_q       <= rd_q;
          res_we_q       <= we_q;
          res_redirect_q <= (br_q && branch_taken_i == 3'd1) || (jmp_q && branch_taken_i == 3'd2);
          illegal_q      <= 1'b0;
        end
      end
    end
  end

  assign instr_ready_o  = (state_q == IDLE) && !rst_i;
  assign rs1_addr_o     = instr_q[19:15];
  assign rs2_addr_o     = instr_q[24:20];
  assign a_in_o         = a_q;
  assign b_in_o         = b_q;
  assign alu_control_o  = ctl_q;
  assign pc_o           = pc_q;
  assign tick_idex_o    = (state_q == ISSUE);
  assign res_valid_o    = (state_q == DONE);
  assign res_data_o     = res_data_q;
  assign res_rd_o       = res_rd_q;
  assign res_we_o       = res_we_q;
  assign res_redirect_o = res_redirect_q;
  assign res_target_o   = res_target_q;
  assign illegal_o      = illegal_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage sitting between fetch and the ALU. It accepts one RV32I instruction at a time via a valid/ready handshake and reads its source registers from the register file. It drives the ALU operand/control bus with a one-cycle `tick_idex` strobe, waits for the ALU's multi-cycle result to settle, and then emits a single result record containing writeback data and any PC redirect.

## Interface
- `SETTLE_CYCLES`, default 4: cycles spent in WAIT after the issue strobe. Minimum legal value is 4, because the ALU's `branch_taken` is valid only after 4 edges.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `instr_valid` in 1: the fetch side offers `instr`/`instr_pc`.
- `instr_ready` out 1: high only in IDLE and not in reset.
- `instr` in 32: RV32I instruction word.
- `instr_pc` in 32: PC of `instr`.
- `flush` in 1: abort the in-flight instruction.
- `rs1_addr`, `rs2_addr` out 5 each: register file read addresses.
- `rs1_data`, `rs2_data` in 32 each: register file read data, combinational from the addresses.
- `a_in`, `b_in` out 32 each: ALU operands.
- `alu_control` out 5: ALU opcode.
- `pc` out 32: PC passed to the ALU.
- `tick_idex` out 1: one-cycle load strobe to the ALU.
- `alu_result` in 32: ALU result.
- `branch_taken` in 3: 0 means not taken, 1 means taken to pc+imm, 2 means jump.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out 32: writeback value.
- `res_rd` out 5: destination register.
- `res_we` out 1: register write enable.
- `res_redirect` out 1: a PC redirect is required.
- `res_target` out 32: redirect target.
- `illegal` out 1: instruction is not handled by this stage. Valid with `res_valid`.

## Operation
- FSM states: IDLE, READ, ISSUE, WAIT, DONE.
- IDLE:
  - On `instr_valid & instr_ready`, latch `instr` and `instr_pc`.
  - Drive `rs1_addr` = instr[19:15] and `rs2_addr` = instr[24:20] from the latched copy.
  - Go to READ.
- READ:
  - Decode the instruction, sample `rs1_data`/`rs2_data`, and register `a_in`, `b_in`, `alu_control`, `pc`, target, rd, and we.
  - Go to ISSUE, or to DONE with `illegal` set.
- ISSUE: `tick_idex`=1 for exactly this cycle; operands stay stable. Go to WAIT.
- WAIT: count `SETTLE_CYCLES` cycles. On the edge ending the last WAIT cycle, capture `alu_result` and `branch_taken`. Go to DONE.
- DONE: `res_valid`=1 for one cycle, then go to IDLE.
- Opcode map (alu_control):
  - ADD/ADDI 00000, SUB 00001, AND/ANDI 00011, OR/ORI 00100, XOR/XORI 00101.
  - SLL/SLLI 01000, SRL/SRLI 01010, SRA/SRAI 01011.
  - BLT 00110, BEQ 00111, BLTU 01001, BNE 01110, BGE 01111, BGEU 10000.
  - LUI 01100, AUIPC 01101, JALR 10001, JAL 10010.
- Operands:
  - R-type: a=rs1, b=rs2.
  - I-type ALU: b = sign-extended imm[11:0]. For shifts, b = {27'b0, shamt}.
  - Branches: a=rs1, b=rs2.
  - LUI/AUIPC: b = {instr[31:12], 12'b0}.
  - JAL: a=0, b=0.
  - JALR: a=rs1, b=sign-extended I-imm.
  - `pc` = latched `instr_pc` in all cases.
- Target, computed in READ:
  - Branch: pc + B-imm.
  - JAL: pc + J-imm.
  - JALR: (rs1 + I-imm) & ~1.
  - All 32-bit, wrap-around modulo 2^32.
- Result fields:
  - `res_data` = captured `alu_result`.
  - `res_we` = 1 only for writing classes (R, I-ALU, LUI, AUIPC, JAL, JALR) with rd != 0.
  - `res_redirect` = 1 if (branch and `branch_taken`==1) or (JAL/JALR and `branch_taken`==2).
- Illegal instructions skip ISSUE/WAIT and produce `illegal`=1, `res_we`=0, `res_redirect`=0. Illegal classes:
  - Loads, stores, FENCE, SYSTEM, SLT/SLTI/SLTU/SLTIU.
  - Any undefined funct3/funct7.
  - Shift-immediate with a non-zero funct7 other than SRAI's.

## Timing
- Accept at cycle T.
- READ at T+1.
- ISSUE at T+2 (`tick_idex`=1).
- WAIT at T+3..T+2+S.
- DONE at T+3+S (`res_valid`=1).
- With the default S=4, latency from accept to `res_valid` is 7 cycles; next accept is possible no earlier than T+8.
- Illegal path: `res_valid` at T+2.
- `tick_idex` is never high two cycles in a row, and is never high outside ISSUE.
- Reset values:
  - State IDLE; `instr_ready`=0 while `rst`=1, 1 in the first cycle after.
  - All other outputs 0, including `tick_idex`, `res_valid`, `illegal`, `alu_control`=00000, `a_in`/`b_in`/`pc`=0.
- Reset mid-operation: go to IDLE on the next edge, with no `res_valid` and no further `tick_idex`.
- `flush` in READ, ISSUE, or WAIT: go to IDLE on the next edge and suppress `res_valid`.
  - `flush` together with `tick_idex` in ISSUE still lets the strobe occur, but the result is discarded.
- `flush` in IDLE or DONE is ignored; a DONE result is already committed.
- `res_*` fields hold their values until the next DONE; only `res_valid` qualifies them.

## Test plan
- ADDI x5, x1, -1 with x1=0x00000010, S=4: `tick_idex` at T+2 with b=0xFFFFFFFF and `alu_control`=00000 -> at T+7, `res_valid`=1, `res_data`=0x0000000F, `res_rd`=5, `res_we`=1.
- BEQ at pc 0x100, imm +0x20, rs1=rs2=7 -> `res_redirect`=1, `res_target`=0x120. Same instruction with rs2=8 -> `res_redirect`=0, `res_we`=0.
- JALR x1, 4(x2) with x2=0x203, pc=0x40 -> `res_data`=0x44, `res_target`=0x206, `res_redirect`=1, `res_we`=1.
- LW (opcode 0000011) -> `res_valid` at T+2 with `illegal`=1, no `tick_idex` pulse. ADD with rd=x0 -> `res_we`=0.
- `flush` asserted at T+4 during WAIT -> IDLE at T+5, no `res_valid`, `instr_ready`=1 at T+5.
- `rst` asserted at T+3 -> all outputs 0 next cycle. A back-to-back `instr_valid` held high is accepted only when `instr_ready`=1, and is never accepted during DONE.
